// File: rtl/line_mem_responder.sv
// Memory-side responder for the 128-bit cache line interface.
// Captures one line read or line write, waits a fixed latency, performs the
// access on the internal line array and pulses mem_ready for one cycle.
//
// Handshake: the cache raises mem_read and/or mem_write and holds the request
// until it sees mem_ready=1. Requests are sampled only while idle. The request
// fields are copied on the capture edge, and later changes are ignored until
// completion. mem_ready is a single-cycle pulse, and mem_rdata is meaningful
// only in that cycle. If both request lines are set, the request is a write.
module line_mem_responder #(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         busy,
  output logic [15:0]  rd_cnt,
  output logic [15:0]  wr_cnt,
  output logic [1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               op_wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [127:0]       wdata_q;
  logic [127:0]       rdata_q;
  logic               capture;
  logic               access;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [127:0]       acc_wdata;
  logic               unused_addr_bits;

  logic [127:0] line_mem [2**IDX_W];

  // Address bits above the index only select aliases of the same entry.
  assign unused_addr_bits = ^mem_addr[27:IDX_W];

  // With a one-cycle latency the access happens on the capture edge, so the
  // access fields come straight from the inputs in that case.
  assign acc_wr    = capture ? mem_write : op_wr_q;
  assign acc_idx   = capture ? mem_addr[IDX_W-1:0] : idx_q;
  assign acc_wdata = capture ? mem_wdata : wdata_q;

  // Next-state logic: capture in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          capture = 1'b1;
          cnt_d   = LAT_M1;
          if (LATENCY == 1) begin
            access  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 8'd1) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state, request copy, read data register and completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        op_wr_q <= mem_write;
        idx_q   <= mem_addr[IDX_W-1:0];
        wdata_q <= mem_wdata;
      end
      if (access) begin
        rdata_q <= acc_wr ? '0 : line_mem[acc_idx];
      end else if (state_q == RESP) begin
        rdata_q <= '0;
      end
      if (state_q == RESP) begin
        if (op_wr_q) wr_cnt <= wr_cnt + 16'd1;
        else         rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

  // Line array is not reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (access && acc_wr && rst_n) begin
      line_mem[acc_idx] <= acc_wdata;
    end
  end

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = rdata_q;
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: a vector table of line
// transactions plus hand-written reset-abort and back-to-back sequences.
module tb_line_mem_responder;

  localparam int LATENCY = 8;
  localparam int IDX_W   = 8;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic [15:0]  rd_cnt;
  logic [15:0]  wr_cnt;
  logic [1:0]   fsm_state;

  line_mem_responder #(
    .LATENCY (LATENCY),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt),
    .fsm_state (fsm_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp;
  int           n_err;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_rd;
  logic [15:0]  exp_wr;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: present a request and push the data expected with its mem_ready.
  task automatic start_req(input logic rd, input logic wr, input logic [27:0] addr,
                           input logic [127:0] wdata, input logic [127:0] exp);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    exp_q.push_back(exp);
  endtask

  // Wait for mem_ready, counting cycles from the current negedge. Cycles
  // before the capture edge are expected idle; after it, busy must hold and
  // address/data are scrambled to show the captured copy is used.
  task automatic wait_resp(input string name, input int exp_lat);
    int           k;
    bit           seen;
    bit           busy_ok;
    logic [127:0] e;
    seen    = 1'b0;
    busy_ok = 1'b1;
    k       = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (busy !== (k > exp_lat - LATENCY)) busy_ok = 1'b0;
      if (mem_ready === 1'b1) begin
        seen = 1'b1;
      end else if (k > exp_lat - LATENCY) begin
        mem_addr  = 28'($urandom);
        mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: mem_ready not seen within %0d cycles", name, k);
      if (exp_q.size() > 0) e = exp_q.pop_front();
    end else begin
      e = exp_q.pop_front();
      check({name, "_rdata"}, mem_rdata, e);
      check({name, "_latency"}, 128'(k), 128'(exp_lat));
      check({name, "_busy"}, 128'(busy_ok), 128'(1));
    end
  endtask

  // Release the request in the mem_ready cycle and check the following cycle.
  task automatic finish_txn(input string name, input logic wr);
    if (wr) exp_wr = exp_wr + 16'd1;
    else    exp_rd = exp_rd + 16'd1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check({name, "_ready_pulse"}, 128'(mem_ready), 128'(0));
    check({name, "_idle_busy"}, 128'(busy), 128'(0));
    check({name, "_rd_cnt"}, 128'(rd_cnt), 128'(exp_rd));
    check({name, "_wr_cnt"}, 128'(wr_cnt), 128'(exp_wr));
  endtask

  initial begin
    bit ready_seen;

    n_cmp     = 0;
    n_err     = 0;
    exp_rd    = '0;
    exp_wr    = '0;
    rst_n     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    vecs[0] = '{1'b0, 1'b1, 28'h10,      128'h0123456789ABCDEF0123456789ABCDEF, 128'h0};
    vecs[1] = '{1'b1, 1'b0, 28'h10,      128'h0, 128'h0123456789ABCDEF0123456789ABCDEF};
    vecs[2] = '{1'b1, 1'b1, 28'h20,      {16{8'hAA}}, 128'h0};
    vecs[3] = '{1'b1, 1'b0, 28'h20,      128'h0, {16{8'hAA}}};
    vecs[4] = '{1'b0, 1'b1, 28'h005,     {8{16'hA5C3}}, 128'h0};
    vecs[5] = '{1'b1, 1'b0, 28'h105,     128'h0, {8{16'hA5C3}}};
    vecs[6] = '{1'b0, 1'b1, 28'h30,      {4{32'h3030_0303}}, 128'h0};
    vecs[7] = '{1'b0, 1'b1, 28'h0FF,     {4{32'hFEED_BEEF}}, 128'h0};
    vecs[8] = '{1'b1, 1'b0, 28'hABCDEFF, 128'h0, {4{32'hFEED_BEEF}}};
    vecs[9] = '{1'b1, 1'b0, 28'h30,      128'h0, {4{32'h3030_0303}}};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(mem_ready), 128'(0));
    check("rst_rdata", mem_rdata, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_rd_cnt", 128'(rd_cnt), 128'(0));
    check("rst_wr_cnt", 128'(wr_cnt), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      start_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      wait_resp($sformatf("vec%0d", i), LATENCY);
      finish_txn($sformatf("vec%0d", i), vecs[i].wr);
    end

    // Reset during the wait of a write to 0x30: the write must be dropped.
    mem_write = 1'b1;
    mem_addr  = 28'h30;
    mem_wdata = {4{32'hDEAD_DEAD}};
    repeat (3) @(negedge clk);
    rst_n     = 1'b0;
    mem_write = 1'b0;
    exp_rd    = '0;
    exp_wr    = '0;
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_ready", 128'(mem_ready), 128'(0));
    check("abort_rdata", mem_rdata, 128'h0);
    check("abort_rd_cnt", 128'(rd_cnt), 128'(0));
    check("abort_wr_cnt", 128'(wr_cnt), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ready_seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_ready !== 1'b0 || busy !== 1'b0) ready_seen = 1'b1;
    end
    check("abort_no_ready", 128'(ready_seen), 128'(0));
    start_req(1'b1, 1'b0, 28'h30, 128'h0, {4{32'h3030_0303}});
    wait_resp("abort_readback", LATENCY);
    finish_txn("abort_readback", 1'b0);

    // Write-back then refill held back-to-back: the refill is captured at the
    // end of the idle cycle right after the write's mem_ready.
    start_req(1'b0, 1'b1, 28'h40, {4{32'h4040_C0DE}}, 128'h0);
    wait_resp("b2b_wb", LATENCY);
    exp_wr = exp_wr + 16'd1;
    start_req(1'b1, 1'b0, 28'h10, 128'h0, 128'h0123456789ABCDEF0123456789ABCDEF);
    wait_resp("b2b_refill", LATENCY + 1);
    finish_txn("b2b_refill", 1'b0);
    start_req(1'b1, 1'b0, 28'h40, 128'h0, {4{32'h4040_C0DE}});
    wait_resp("b2b_check", LATENCY);
    finish_txn("b2b_check", 1'b0);

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
